// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module : systolic_pkg
// Brief  : Width helpers shared by the systolic result-drain logic.
// Rev    : 1.0  initial release
// ============================================================================
package systolic_pkg;

   // $clog2 returns 0 for a range of 1; a zero-width vector is not legal
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int addr_width(input int m, input int n1);
      return clog2_min1((m * m) / n1);
   endfunction

   function automatic int ctr_width(input int range_n);
      return clog2_min1(range_n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/drain_lane_ctr.sv
`default_nettype none
// ============================================================================
// Module : drain_lane_ctr
// Brief  : One result-row lane: beat/column-tile/row-tile counters, bank
//          address generation and registered write port.
// Rev    : 1.0  initial release
// ============================================================================
module drain_lane_ctr
   import systolic_pkg::*;
#(
   parameter int D_W_ACC = 16,
   parameter int N1      = 4,
   parameter int N2      = 4,
   parameter int M       = 8,
   parameter int ADDR_W  = addr_width(M, N1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic [D_W_ACC-1:0] d,
   input  logic               valid,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [D_W_ACC-1:0] wr_data,
   output logic               lane_last
);

   localparam int c_KW = ctr_width(N2);
   localparam int c_CW = ctr_width(M / N2);
   localparam int c_RW = ctr_width(M / N1);

   localparam logic [c_KW-1:0] c_K_MAX = c_KW'(N2 - 1);
   localparam logic [c_CW-1:0] c_C_MAX = c_CW'((M / N2) - 1);
   localparam logic [c_RW-1:0] c_R_MAX = c_RW'((M / N1) - 1);

   logic [c_KW-1:0]    r_k;
   logic [c_CW-1:0]    r_c;
   logic [c_RW-1:0]    r_r;
   logic               r_wr_en;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic [D_W_ACC-1:0] r_wr_data;

   logic              w_k_max;
   logic              w_c_max;
   logic              w_r_max;
   logic              w_beat;
   logic [ADDR_W-1:0] w_addr;

   assign w_k_max = (r_k == c_K_MAX);
   assign w_c_max = (r_c == c_C_MAX);
   assign w_r_max = (r_r == c_R_MAX);
   assign w_beat  = valid && !clear;

   // Columns arrive highest-first within a tile, hence the N2-1-k term
   assign w_addr = ADDR_W'(int'(r_r) * M + int'(r_c) * N2 + (N2 - 1) - int'(r_k));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k       <= '0;
         r_c       <= '0;
         r_r       <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (clear) begin
            r_k <= '0;
            r_c <= '0;
            r_r <= '0;
         end else if (valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr;
            r_wr_data <= d;
            if (w_k_max) begin
               r_k <= '0;
               if (w_c_max) begin
                  r_c <= '0;
                  r_r <= w_r_max ? '0 : r_r + 1'b1;
               end else begin
                  r_c <= r_c + 1'b1;
               end
            end else begin
               r_k <= r_k + 1'b1;
            end
         end
      end
   end

   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign lane_last = w_beat && w_k_max && w_c_max && w_r_max;

endmodule
`default_nettype wire

// File: rtl/systolic_drain.sv
`default_nettype none
// ============================================================================
// Module : systolic_drain
// Brief  : Drains skewed systolic-array result rows into N1 result banks and
//          signals completion of each full MxM matrix.
// Rev    : 1.0  initial release
// ============================================================================
module systolic_drain
   import systolic_pkg::*;
#(
   parameter int D_W_ACC = 16,
   parameter int N1      = 4,
   parameter int N2      = 4,
   parameter int M       = 8,
   localparam int ADDR_W = addr_width(M, N1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic [D_W_ACC-1:0] D       [N1],
   input  logic [N1-1:0]      valid_D,
   output logic [N1-1:0]      wr_en,
   output logic [ADDR_W-1:0]  wr_addr [N1],
   output logic [D_W_ACC-1:0] wr_data [N1],
   output logic               busy,
   output logic               done
);

   logic [N1-1:0] w_lane_last;
   logic [N1-1:0] r_flags;
   logic          r_busy;
   logic          r_done;
   logic          w_fire;

   generate
      for (genvar gi = 0; gi < N1; gi++) begin : g_lane
         drain_lane_ctr #(
            .D_W_ACC (D_W_ACC),
            .N1      (N1),
            .N2      (N2),
            .M       (M),
            .ADDR_W  (ADDR_W)
         ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .d         (D[gi]),
            .valid     (valid_D[gi]),
            .wr_en     (wr_en[gi]),
            .wr_addr   (wr_addr[gi]),
            .wr_data   (wr_data[gi]),
            .lane_last (w_lane_last[gi])
         );
      end
   endgenerate

   assign w_fire = &r_flags;

   // A lane finishing a new matrix in the firing cycle keeps its fresh flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flags <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (clear) begin
         r_flags <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done  <= w_fire;
         r_flags <= (w_fire ? '0 : r_flags) | w_lane_last;
         if (w_fire) begin
            r_busy <= 1'b0;
         end else if (|valid_D) begin
            r_busy <= 1'b1;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// ============================================================================
// Module : tb_systolic_drain
// Brief  : Directed self-checking bench for systolic_drain (N1=N2=4, M=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_systolic_drain;

   localparam int D_W_ACC = 16;
   localparam int N1      = 4;
   localparam int N2      = 4;
   localparam int M       = 8;
   localparam int AW      = 4;
   localparam int BEATS   = (M * M) / N1;

   logic               clk;
   logic               rst;
   logic               clear;
   logic [D_W_ACC-1:0] D       [N1];
   logic [N1-1:0]      valid_D;
   logic [N1-1:0]      wr_en;
   logic [AW-1:0]      wr_addr [N1];
   logic [D_W_ACC-1:0] wr_data [N1];
   logic               busy;
   logic               done;

   systolic_drain #(
      .D_W_ACC (D_W_ACC),
      .N1      (N1),
      .N2      (N2),
      .M       (M)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .D       (D),
      .valid_D (valid_D),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int cnt   [N1];
   int hits  [N1][BEATS];
   int seq;
   int n_writes;
   int n_done;
   logic [N1-1:0] m_flags;
   logic          m_pend;
   logic          m_busy;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", tag, act, exp, $time);
      end
   endtask

   // Beat n of a lane's matrix: r = n/8, c = (n/4)%2, k = n%4
   function automatic int exp_addr(input int n);
      int r, c, k;
      r = n / (N2 * (M / N2));
      c = (n / N2) % (M / N2);
      k = n % N2;
      return r * M + c * N2 + (N2 - 1 - k);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N1; i++) cnt[i] = 0;
      m_flags = '0;
      m_pend  = 1'b0;
      m_busy  = 1'b0;
   endtask

   // One clock: drive inputs, sample 1 ns after the edge, compare every output
   task automatic step(input logic [N1-1:0] v, input logic clr);
      logic [N1-1:0] last;
      valid_D = v;
      clear   = clr;
      for (int i = 0; i < N1; i++) D[i] = 16'(i * 1000 + seq);
      @(posedge clk);
      #1;
      last = '0;
      for (int i = 0; i < N1; i++) begin
         chk($sformatf("wr_en[%0d]", i), 32'(wr_en[i]), 32'(v[i] & ~clr));
         if (v[i] && !clr) begin
            chk($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(exp_addr(cnt[i])));
            chk($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(i * 1000 + seq));
            hits[i][exp_addr(cnt[i])]++;
            n_writes++;
            if (cnt[i] == BEATS - 1) last[i] = 1'b1;
            cnt[i] = (cnt[i] + 1) % BEATS;
         end
      end
      chk("done", 32'(done), 32'(m_pend & ~clr));
      if (done) n_done++;
      if (clr || m_pend) m_busy = 1'b0;
      else if (|v)       m_busy = 1'b1;
      chk("busy", 32'(busy), 32'(m_busy));
      if (clr) begin
         for (int i = 0; i < N1; i++) cnt[i] = 0;
         m_flags = '0;
         m_pend  = 1'b0;
      end else begin
         if (m_pend) m_flags = '0;
         m_flags = m_flags | last;
         m_pend  = &m_flags;
      end
      valid_D = '0;
      clear   = 1'b0;
      seq++;
   endtask

   task automatic clear_hits();
      for (int i = 0; i < N1; i++)
         for (int a = 0; a < BEATS; a++) hits[i][a] = 0;
      n_writes = 0;
      n_done   = 0;
   endtask

   initial begin
      logic [N1-1:0] v;
      rst     = 1'b0;
      clear   = 1'b0;
      valid_D = '0;
      for (int i = 0; i < N1; i++) D[i] = '0;
      seq = 100;
      model_reset();
      clear_hits();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b1;

      // Lane 0: three bursts, data 100..103 on the first
      for (int b = 0; b < 3; b++)
         for (int k = 0; k < N2; k++) step(4'b0001, 1'b0);
      step(4'b0000, 1'b1);

      // Full matrix, lane i skewed by i cycles
      clear_hits();
      for (int t = 0; t < BEATS + N1 - 1 + 3; t++) begin
         for (int i = 0; i < N1; i++) v[i] = (t >= i) && (t < i + BEATS);
         step(v, 1'b0);
      end
      chk("matrix_writes", 32'(n_writes), 64);
      chk("matrix_done_count", 32'(n_done), 1);
      for (int i = 0; i < N1; i++)
         for (int a = 0; a < BEATS; a++)
            chk($sformatf("hit[%0d][%0d]", i, a), 32'(hits[i][a]), 1);

      // Lane 1 burst with a two-cycle gap
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      step(4'b0010, 1'b0);
      step(4'b0010, 1'b0);

      // Clear coincident with beat 2 of a lane-0 burst
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b1);
      chk("clr_busy", 32'(busy), 0);
      chk("clr_no_write", 32'(wr_en[0]), 0);
      step(4'b0001, 1'b0);
      chk("clr_next_addr", 32'(wr_addr[0]), 3);

      // Reset in the middle of a matrix
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      rst = 1'b0;
      #1;
      chk("mid_rst_wr_en", 32'(wr_en), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      for (int i = 0; i < N1; i++) begin
         chk($sformatf("mid_rst_addr[%0d]", i), 32'(wr_addr[i]), 0);
         chk($sformatf("mid_rst_data[%0d]", i), 32'(wr_data[i]), 0);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      step(4'b1111, 1'b0);
      for (int i = 0; i < N1; i++)
         chk($sformatf("post_rst_addr[%0d]", i), 32'(wr_addr[i]), 3);
      step(4'b0000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter D_W_ACC, default 16, accumulator/result data width.
REQ-002 SHALL have parameter N1, default 4, array rows (= result banks).
REQ-003 SHALL have parameter N2, default 4, array columns (= beats per burst).
REQ-004 SHALL have parameter M, default 8, square matrix dimension; M divisible by N1 and N2.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port clear  input  1  synchronous clear of all counters.
REQ-008 SHALL have port D  input  [D_W_ACC-1:0] x N1  result data from the array, one lane per row.
REQ-009 SHALL have port valid_D  input  N1  per-row beat valid.
REQ-010 SHALL have port wr_en  output  N1  per-bank write enable.
REQ-011 SHALL have port wr_addr  output  [$clog2((M*M)/N1)-1:0] x N1  per-bank write address.
REQ-012 SHALL have port wr_data  output  [D_W_ACC-1:0] x N1  per-bank write data.
REQ-013 SHALL have port busy  output  1  matrix drain in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse, full MxM result written.

Function
REQ-015 Each row lane i SHALL act independently; lanes are skewed relative to each other and no inter-lane alignment is assumed.
REQ-016 Lane i SHALL keep a beat counter k (0..N2-1), a column-tile counter c (0..M/N2-1) and a row-tile counter r (0..M/N1-1).
REQ-017 Only cycles with valid_D[i]=1 SHALL advance k; gaps inside a burst are tolerated, and k holds during gaps.
REQ-018 Beat k of tile (r,c) SHALL carry C[r*N1+i][c*N2+(N2-1-k)], i.e. columns arrive highest-first.
REQ-019 The bank-i address SHALL be r*M + c*N2 + (N2-1-k).
REQ-020 wr_en[i], wr_addr[i] and wr_data[i] SHALL be registered with latency exactly 1 cycle from the valid beat; wr_en[i]=0 on all other cycles.
REQ-021 k wrap (N2-1 -> 0) SHALL increment c; c wrap SHALL increment r (c fastest); r wrap SHALL return the lane to (0,0,0) ready for the next matrix.
REQ-022 Lane i SHALL assert an internal lane_last flag on its final beat of the matrix (r, c, k all at their maximum).
REQ-023 done SHALL pulse high for one cycle, one cycle after the write of the last beat of the last lane to finish; all lanes SHALL have completed when it fires.
REQ-024 Per-lane completion flags SHALL be cleared in the same cycle done is asserted.
REQ-025 busy SHALL rise on the cycle after the first valid beat of a matrix on any lane, and fall in the cycle done is asserted.
REQ-026 When clear and a valid beat coincide, clear SHALL win: the beat is dropped, no write is issued, and counters go to zero.
REQ-027 clear SHALL also drop busy, drop completion flags and suppress done.
REQ-028 A lane that receives further valid beats after completing, before done fires, SHALL start the next matrix at (0,0,0) while keeping its completion flag.

Reset
REQ-029 While rst=0, all counters, flags, wr_en, wr_addr, wr_data, busy and done SHALL be 0, asynchronously.
REQ-030 Reset deassertion SHALL be synchronous to clk; reset mid-matrix SHALL discard all progress.

Structure
REQ-031 The shared package systolic_pkg SHALL hold the address-width and counter-width helper functions, including the $clog2-with-minimum-1 guard.
REQ-032 One sub-module, drain_lane_ctr (per-lane k/c/r counters, address, registered write outputs), SHALL be instantiated N1 times; the top level holds only completion tracking, busy and done.

Verification (N1=N2=4, M=8)
REQ-033 Bench SHALL drive lane 0 valid for 4 cycles with data 100..103 and check bank-0 writes at addresses 3,2,1,0, each 1 cycle later.
REQ-034 Bench SHALL drive a second and third lane-0 burst and check addresses 7..4, then 11..8.
REQ-035 Bench SHALL drive the full matrix with lane skew i cycles (16 beats/lane) and check 64 writes, every address 0..15 in every bank hit once, and done one cycle after lane 3's last write.
REQ-036 Bench SHALL drop valid for 2 cycles mid-burst on lane 1 and check the address sequence is unbroken and no write occurs in the gap.
REQ-037 Bench SHALL assert clear coincident with beat 2 of a burst and check no write, busy=0, and the next beat written to address 3.
REQ-038 Bench SHALL assert rst=0 mid-matrix and check all outputs 0 immediately, and that the next matrix starts at address 3 on every lane.
